// File: rtl/falling_state_update.sv
// falling_state_update
// Owns the registered state of the falling tetromino (type, origin row/col,
// orientation) and advances it by at most one action per cycle.
//
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   frame_tick                 one-cycle pulse per video frame
//   spawn, spawn_type          load a new piece (honoured only in IDLE)
//   *_in                       level user inputs, rising-edge detected here
//   *_valid, *_kick            validity checker verdicts for the candidates
//   hard_drop_row              lowest valid origin row for the current piece
//   falling_*                  current piece state
//   rotate_*/move_*/soft_drop_* row/col/orientation candidate states
//   piece_active               high while a piece is owned (FALLING..LOCK)
//   lock_req                   one-cycle pulse, falling_* hold the final spot
module falling_state_update #(
    parameter int GRAVITY_TICKS    = 60,
    parameter int LOCK_DELAY_TICKS = 30,
    parameter int MAX_LOCK_RESETS  = 15,
    parameter int SPAWN_ROW        = 1,
    parameter int SPAWN_COL        = 4
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       frame_tick,
    input  logic       spawn,
    input  logic [3:0] spawn_type,
    input  logic       rotate_R_in,
    input  logic       rotate_L_in,
    input  logic       move_R_in,
    input  logic       move_L_in,
    input  logic       soft_drop_in,
    input  logic       hard_drop_in,
    input  logic       rotate_R_valid,
    input  logic       rotate_L_valid,
    input  logic       move_R_valid,
    input  logic       move_L_valid,
    input  logic       soft_drop_valid,
    input  logic [4:0] rotate_R_row_kick,
    input  logic [4:0] rotate_R_col_kick,
    input  logic [4:0] rotate_L_row_kick,
    input  logic [4:0] rotate_L_col_kick,
    input  logic [4:0] hard_drop_row,
    output logic [3:0] falling_type,
    output logic [4:0] falling_row,
    output logic [4:0] falling_col,
    output logic [1:0] falling_orientation,
    output logic [4:0] rotate_R_row,
    output logic [4:0] rotate_R_col,
    output logic [1:0] rotate_R_orientation,
    output logic [4:0] rotate_L_row,
    output logic [4:0] rotate_L_col,
    output logic [1:0] rotate_L_orientation,
    output logic [4:0] move_R_row,
    output logic [4:0] move_R_col,
    output logic [1:0] move_R_orientation,
    output logic [4:0] move_L_row,
    output logic [4:0] move_L_col,
    output logic [1:0] move_L_orientation,
    output logic [4:0] soft_drop_row,
    output logic [4:0] soft_drop_col,
    output logic [1:0] soft_drop_orientation,
    output logic       piece_active,
    output logic       lock_req
);

    localparam int GW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
    localparam int LW = $clog2(LOCK_DELAY_TICKS + 1);
    localparam int RW = $clog2(MAX_LOCK_RESETS + 2);

    localparam logic [3:0] BLANK = 4'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FALLING = 2'd1,
        S_LOCKING = 2'd2,
        S_LOCK    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      type_q, type_d;
    logic [4:0]      row_q, row_d;
    logic [4:0]      col_q, col_d;
    logic [1:0]      ori_q, ori_d;
    logic [GW-1:0]   grav_cnt_q, grav_cnt_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [RW-1:0]   reset_cnt_q, reset_cnt_d;
    logic [5:0]      prev_q;

    // Input vector in priority order: hard_drop, rotate_R, rotate_L, move_R, move_L, soft_drop
    logic [5:0] in_now;
    logic [5:0] rise;
    assign in_now = {hard_drop_in, rotate_R_in, rotate_L_in, move_R_in, move_L_in, soft_drop_in};
    assign rise   = in_now & ~prev_q;

    // Next-state scratch
    logic          grav_step;
    logic          mv_hit;
    logic          mv_commit;
    logic [4:0]    mv_row;
    logic [4:0]    mv_col;
    logic [1:0]    mv_ori;
    logic [LW-1:0] lock_next;

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            type_q      <= BLANK;
            row_q       <= '0;
            col_q       <= '0;
            ori_q       <= '0;
            grav_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            reset_cnt_q <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ori_q       <= ori_d;
            grav_cnt_q  <= grav_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            reset_cnt_q <= reset_cnt_d;
            prev_q      <= in_now;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        row_d       = row_q;
        col_d       = col_q;
        ori_d       = ori_q;
        grav_cnt_d  = grav_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        reset_cnt_d = reset_cnt_q;
        lock_next   = lock_cnt_q;

        grav_step = frame_tick && (grav_cnt_q == GW'(GRAVITY_TICKS - 1));

        // Highest-priority rotation/move edge. mv_hit blocks every lower-priority
        // action in the same cycle even when the checker rejected it.
        mv_hit    = 1'b0;
        mv_commit = 1'b0;
        mv_row    = row_q;
        mv_col    = col_q;
        mv_ori    = ori_q;
        if (rise[4]) begin
            mv_hit    = 1'b1;
            mv_commit = rotate_R_valid;
            mv_row    = rotate_R_row_kick;
            mv_col    = rotate_R_col_kick;
            mv_ori    = ori_q + 2'd1;
        end else if (rise[3]) begin
            mv_hit    = 1'b1;
            mv_commit = rotate_L_valid;
            mv_row    = rotate_L_row_kick;
            mv_col    = rotate_L_col_kick;
            mv_ori    = ori_q - 2'd1;
        end else if (rise[2]) begin
            mv_hit    = 1'b1;
            mv_commit = move_R_valid;
            mv_col    = col_q + 5'd1;
        end else if (rise[1]) begin
            mv_hit    = 1'b1;
            mv_commit = move_L_valid;
            mv_col    = col_q - 5'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (spawn) begin
                    type_d      = spawn_type;
                    row_d       = 5'(SPAWN_ROW);
                    col_d       = 5'(SPAWN_COL);
                    ori_d       = 2'd0;
                    grav_cnt_d  = '0;
                    lock_cnt_d  = '0;
                    reset_cnt_d = '0;
                    state_d     = S_FALLING;
                end
            end

            S_FALLING: begin
                lock_cnt_d = '0;
                if (frame_tick) begin
                    grav_cnt_d = grav_step ? '0 : grav_cnt_q + GW'(1);
                end
                if (rise[5]) begin
                    row_d   = hard_drop_row;
                    state_d = S_LOCK;
                end else begin
                    if (mv_hit) begin
                        if (mv_commit) begin
                            row_d = mv_row;
                            col_d = mv_col;
                            ori_d = mv_ori;
                        end
                    end else if (rise[0] || grav_step) begin
                        if (soft_drop_valid) begin
                            row_d      = row_q + 5'd1;
                            grav_cnt_d = '0;
                        end
                    end
                    // Grounded check uses the verdict for the current position
                    if (!soft_drop_valid) begin
                        state_d = S_LOCKING;
                    end
                end
            end

            S_LOCKING: begin
                if (frame_tick) begin
                    lock_next = lock_cnt_q + LW'(1);
                end
                if (rise[5]) begin
                    row_d   = hard_drop_row;
                    state_d = S_LOCK;
                end else begin
                    if (mv_commit) begin
                        row_d = mv_row;
                        col_d = mv_col;
                        ori_d = mv_ori;
                        if (reset_cnt_q < RW'(MAX_LOCK_RESETS)) begin
                            lock_next   = '0;
                            reset_cnt_d = reset_cnt_q + RW'(1);
                        end
                    end
                    if (soft_drop_valid) begin
                        lock_next = '0;
                        state_d   = S_FALLING;
                    end else if (lock_next == LW'(LOCK_DELAY_TICKS)) begin
                        state_d = S_LOCK;
                    end
                    lock_cnt_d = lock_next;
                end
            end

            S_LOCK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        falling_type          = type_q;
        falling_row           = row_q;
        falling_col           = col_q;
        falling_orientation   = ori_q;
        piece_active          = (state_q != S_IDLE);
        lock_req              = (state_q == S_LOCK);

        rotate_R_row          = row_q;
        rotate_R_col          = col_q;
        rotate_R_orientation  = ori_q + 2'd1;
        rotate_L_row          = row_q;
        rotate_L_col          = col_q;
        rotate_L_orientation  = ori_q - 2'd1;
        move_R_row            = row_q;
        move_R_col            = col_q + 5'd1;
        move_R_orientation    = ori_q;
        // 0 wraps to 31 so the checker rejects a move off the left wall
        move_L_row            = row_q;
        move_L_col            = col_q - 5'd1;
        move_L_orientation    = ori_q;
        soft_drop_row         = row_q + 5'd1;
        soft_drop_col         = col_q;
        soft_drop_orientation = ori_q;
    end

endmodule

// File: tb/tb_falling_state_update.sv
module tb_falling_state_update;

    localparam int G  = 2;
    localparam int LD = 3;
    localparam int MR = 2;

    localparam logic [5:0] A_NONE = 6'b000000;
    localparam logic [5:0] A_HD   = 6'b100000;
    localparam logic [5:0] A_RR   = 6'b010000;
    localparam logic [5:0] A_RL   = 6'b001000;
    localparam logic [5:0] A_MR   = 6'b000100;
    localparam logic [5:0] A_ML   = 6'b000010;
    localparam logic [4:0] V_ALL  = 5'b11111;
    localparam logic [4:0] V_GND  = 5'b11110;

    localparam int P_IDLE = 0, P_FALL = 1, P_LOCKING = 2, P_LOCK = 3;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic frame_tick = 1'b0, spawn = 1'b0;
    logic [3:0] spawn_type = '0;
    logic rotate_R_in = 0, rotate_L_in = 0, move_R_in = 0, move_L_in = 0;
    logic soft_drop_in = 0, hard_drop_in = 0;
    logic rotate_R_valid = 0, rotate_L_valid = 0, move_R_valid = 0, move_L_valid = 0;
    logic soft_drop_valid = 0;
    logic [4:0] rotate_R_row_kick = '0, rotate_R_col_kick = '0;
    logic [4:0] rotate_L_row_kick = '0, rotate_L_col_kick = '0;
    logic [4:0] hard_drop_row = '0;

    logic [3:0] falling_type;
    logic [4:0] falling_row, falling_col;
    logic [1:0] falling_orientation;
    logic [4:0] rotate_R_row, rotate_R_col, rotate_L_row, rotate_L_col;
    logic [4:0] move_R_row, move_R_col, move_L_row, move_L_col;
    logic [4:0] soft_drop_row, soft_drop_col;
    logic [1:0] rotate_R_orientation, rotate_L_orientation, move_R_orientation;
    logic [1:0] move_L_orientation, soft_drop_orientation;
    logic piece_active, lock_req;

    falling_state_update #(
        .GRAVITY_TICKS(G), .LOCK_DELAY_TICKS(LD), .MAX_LOCK_RESETS(MR),
        .SPAWN_ROW(1), .SPAWN_COL(4)
    ) dut (
        .clk(clk), .rst_l(rst_l), .frame_tick(frame_tick), .spawn(spawn),
        .spawn_type(spawn_type),
        .rotate_R_in(rotate_R_in), .rotate_L_in(rotate_L_in),
        .move_R_in(move_R_in), .move_L_in(move_L_in),
        .soft_drop_in(soft_drop_in), .hard_drop_in(hard_drop_in),
        .rotate_R_valid(rotate_R_valid), .rotate_L_valid(rotate_L_valid),
        .move_R_valid(move_R_valid), .move_L_valid(move_L_valid),
        .soft_drop_valid(soft_drop_valid),
        .rotate_R_row_kick(rotate_R_row_kick), .rotate_R_col_kick(rotate_R_col_kick),
        .rotate_L_row_kick(rotate_L_row_kick), .rotate_L_col_kick(rotate_L_col_kick),
        .hard_drop_row(hard_drop_row),
        .falling_type(falling_type), .falling_row(falling_row),
        .falling_col(falling_col), .falling_orientation(falling_orientation),
        .rotate_R_row(rotate_R_row), .rotate_R_col(rotate_R_col),
        .rotate_R_orientation(rotate_R_orientation),
        .rotate_L_row(rotate_L_row), .rotate_L_col(rotate_L_col),
        .rotate_L_orientation(rotate_L_orientation),
        .move_R_row(move_R_row), .move_R_col(move_R_col),
        .move_R_orientation(move_R_orientation),
        .move_L_row(move_L_row), .move_L_col(move_L_col),
        .move_L_orientation(move_L_orientation),
        .soft_drop_row(soft_drop_row), .soft_drop_col(soft_drop_col),
        .soft_drop_orientation(soft_drop_orientation),
        .piece_active(piece_active), .lock_req(lock_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] typ;
        logic [4:0] row;
        logic [4:0] col;
        logic [1:0] ori;
        logic       pa;
        logic       lr;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    int m_phase, m_type, m_row, m_col, m_ori, m_grav, m_lock, m_resets;
    bit m_prev[6];

    task automatic model_reset();
        m_phase = P_IDLE; m_type = 0; m_row = 0; m_col = 0; m_ori = 0;
        m_grav = 0; m_lock = 0; m_resets = 0;
        for (int i = 0; i < 6; i++) m_prev[i] = 1'b0;
    endtask

    // Applies rotation/move number a (1=rotR,2=rotL,3=movR,4=movL); returns 1 if committed
    function automatic bit lateral(int a);
        case (a)
            1: if (rotate_R_valid) begin
                   m_row = int'(rotate_R_row_kick); m_col = int'(rotate_R_col_kick);
                   m_ori = (m_ori + 1) % 4; return 1'b1;
               end
            2: if (rotate_L_valid) begin
                   m_row = int'(rotate_L_row_kick); m_col = int'(rotate_L_col_kick);
                   m_ori = (m_ori + 3) % 4; return 1'b1;
               end
            3: if (move_R_valid) begin m_col = (m_col + 1) % 32; return 1'b1; end
            4: if (move_L_valid) begin m_col = (m_col + 31) % 32; return 1'b1; end
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic model_step();
        bit cur[6];
        int act;
        bit gstep, c;
        int lk;
        cur = '{hard_drop_in, rotate_R_in, rotate_L_in, move_R_in, move_L_in, soft_drop_in};
        act = -1;
        for (int i = 0; i < 6; i++) begin
            if (act < 0 && cur[i] && !m_prev[i]) act = i;
        end
        for (int i = 0; i < 6; i++) m_prev[i] = cur[i];
        case (m_phase)
            P_IDLE: if (spawn) begin
                m_type = int'(spawn_type); m_row = 1; m_col = 4; m_ori = 0;
                m_grav = 0; m_lock = 0; m_resets = 0; m_phase = P_FALL;
            end
            P_FALL: begin
                gstep = frame_tick && (m_grav == G - 1);
                if (frame_tick) m_grav = (m_grav + 1) % G;
                m_lock = 0;
                if (act == 0) begin
                    m_row = int'(hard_drop_row); m_phase = P_LOCK;
                end else begin
                    if (act < 0 && gstep) act = 6;
                    if (act >= 1 && act <= 4) c = lateral(act);
                    if ((act == 5 || act == 6) && soft_drop_valid) begin
                        m_row = (m_row + 1) % 32; m_grav = 0;
                    end
                    if (!soft_drop_valid) m_phase = P_LOCKING;
                end
            end
            P_LOCKING: begin
                lk = m_lock + (frame_tick ? 1 : 0);
                if (act == 0) begin
                    m_row = int'(hard_drop_row); m_phase = P_LOCK;
                end else begin
                    c = (act >= 1 && act <= 4) ? lateral(act) : 1'b0;
                    if (c && m_resets < MR) begin lk = 0; m_resets++; end
                    if (soft_drop_valid) begin m_phase = P_FALL; lk = 0; end
                    else if (lk >= LD) m_phase = P_LOCK;
                    m_lock = lk;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.typ = 4'(m_type); e.row = 5'(m_row); e.col = 5'(m_col); e.ori = 2'(m_ori);
        e.pa = (m_phase != P_IDLE); e.lr = (m_phase == P_LOCK);
        return e;
    endfunction

    function automatic logic [59:0] cand_of(exp_t e);
        return {e.row, e.col, 2'((e.ori + 1) % 4),
                e.row, e.col, 2'((e.ori + 3) % 4),
                e.row, 5'((e.col + 1) % 32), e.ori,
                e.row, 5'((e.col + 31) % 32), e.ori,
                5'((e.row + 1) % 32), e.col, e.ori};
    endfunction

    initial model_reset();

    always @(posedge clk) begin
        if (!rst_l) model_reset();
        else model_step();
        exp_q.push_back(model_out());
    end

    // Monitor: compares every presented state against the scoreboard queue
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", {falling_type, falling_row, falling_col, falling_orientation,
                            piece_active, lock_req}, e);
            check("candidates",
                  {rotate_R_row, rotate_R_col, rotate_R_orientation,
                   rotate_L_row, rotate_L_col, rotate_L_orientation,
                   move_R_row, move_R_col, move_R_orientation,
                   move_L_row, move_L_col, move_L_orientation,
                   soft_drop_row, soft_drop_col, soft_drop_orientation}, cand_of(e));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [5:0] a, input logic [4:0] v, input logic ft);
        {hard_drop_in, rotate_R_in, rotate_L_in, move_R_in, move_L_in, soft_drop_in} = a;
        {rotate_R_valid, rotate_L_valid, move_R_valid, move_L_valid, soft_drop_valid} = v;
        frame_tick = ft;
        @(posedge clk);
        #1;
    endtask

    task automatic do_spawn(input logic [3:0] t);
        spawn = 1'b1; spawn_type = t;
        cyc(A_NONE, V_ALL, 1'b0);
        spawn = 1'b0;
    endtask

    initial begin
        logic [5:0] a;
        logic [4:0] v;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {falling_type, falling_row, falling_col, falling_orientation,
                                piece_active, lock_req}, 18'd0);
        rst_l = 1'b1;

        do_spawn(4'd6);
        check("spawn_T", {falling_type, falling_row, falling_col, falling_orientation,
                          piece_active, lock_req}, {4'd6, 5'd1, 5'd4, 2'd0, 1'b1, 1'b0});

        repeat (4) begin cyc(A_ML, V_ALL, 1'b0); cyc(A_NONE, V_ALL, 1'b0); end
        cyc(A_ML, 5'b11101, 1'b0);
        cyc(A_NONE, V_ALL, 1'b0);
        check("left_wall_col", falling_col, 5'd0);

        cyc(A_MR | A_ML, V_ALL, 1'b0);
        check("mr_beats_ml", falling_col, 5'd1);
        cyc(A_NONE, V_ALL, 1'b0);

        repeat (4) cyc(A_NONE, V_ALL, 1'b1);
        check("gravity_row", falling_row, 5'd3);

        rotate_L_row_kick = 5'd3; rotate_L_col_kick = 5'd1;
        cyc(A_RL, V_ALL, 1'b0);
        cyc(A_NONE, V_ALL, 1'b0);
        check("rotL_to_L", falling_orientation, 2'd3);
        rotate_R_row_kick = 5'd5; rotate_R_col_kick = 5'd3;
        cyc(A_RR, V_ALL, 1'b0);
        check("rotR_kick", {falling_row, falling_col, falling_orientation}, {5'd5, 5'd3, 2'd0});
        cyc(A_NONE, V_ALL, 1'b0);
        rotate_R_row_kick = 5'd9; rotate_R_col_kick = 5'd9;
        cyc(A_RR, 5'b01111, 1'b0);
        check("rotR_invalid", {falling_row, falling_col, falling_orientation}, {5'd5, 5'd3, 2'd0});
        cyc(A_NONE, V_ALL, 1'b0);

        cyc(A_NONE, V_GND, 1'b0);
        cyc(A_NONE, V_GND, 1'b1);
        cyc(A_NONE, V_GND, 1'b1);
        check("no_early_lock", lock_req, 1'b0);
        cyc(A_NONE, V_GND, 1'b1);
        check("lock_pulse", {lock_req, piece_active}, 2'b11);
        cyc(A_NONE, V_GND, 1'b0);
        check("after_lock", {lock_req, piece_active}, 2'b00);

        do_spawn(4'd2);
        cyc(A_NONE, V_GND, 1'b0);
        repeat (3) begin
            cyc(A_NONE, V_GND, 1'b1);
            cyc(A_NONE, V_GND, 1'b1);
            cyc(A_MR, V_GND, 1'b0);
            check("reset_no_lock", lock_req, 1'b0);
        end
        cyc(A_NONE, V_GND, 1'b1);
        check("reset_cap_lock", {lock_req, falling_col}, {1'b1, 5'd7});
        cyc(A_NONE, V_GND, 1'b0);

        do_spawn(4'd3);
        hard_drop_row = 5'd18;
        cyc(A_HD, V_ALL, 1'b0);
        check("hard_drop", {falling_row, lock_req}, {5'd18, 1'b1});
        cyc(A_NONE, V_ALL, 1'b0);
        check("hard_drop_idle", {piece_active, lock_req}, 2'b00);

        do_spawn(4'd5);
        cyc(A_NONE, V_GND, 1'b0);
        cyc(A_NONE, V_GND, 1'b1);
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        check("async_reset", {falling_type, falling_row, falling_col, falling_orientation,
                              piece_active, lock_req}, 18'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_l = 1'b1;

        repeat (3000) begin
            a = '0;
            for (int i = 0; i < 6; i++) a[i] = ($urandom_range(0, 3) == 0);
            if (a[5]) a[5] = ($urandom_range(0, 3) == 0);
            v = '0;
            for (int i = 1; i < 5; i++) v[i] = ($urandom_range(0, 3) != 0);
            v[0] = ($urandom_range(0, 6) != 0);
            spawn = ($urandom_range(0, 2) == 0);
            spawn_type = 4'($urandom);
            rotate_R_row_kick = 5'($urandom); rotate_R_col_kick = 5'($urandom);
            rotate_L_row_kick = 5'($urandom); rotate_L_col_kick = 5'($urandom);
            hard_drop_row = 5'($urandom);
            cyc(a, v, 1'($urandom));
        end
        spawn = 1'b0;
        cyc(A_NONE, V_ALL, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
